// File: rtl/traffic_light_ctrl.sv
// Demand-actuated two-approach intersection controller with all-red clearance,
// a pedestrian walk phase and a flashing fault mode. Lamp outputs decode from flops only.
module traffic_light_ctrl #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MAIN_MIN   = 8,
    parameter int unsigned SIDE_GREEN = 6,
    parameter int unsigned YELLOW     = 3,
    parameter int unsigned ALLRED     = 2,
    parameter int unsigned WALK       = 5,
    parameter int unsigned FLASH_CYC  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       flash,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    localparam longint unsigned MaxDur = 64'd1 << CNT_W;

    if (MAIN_MIN < 1 || MAIN_MIN > MaxDur) begin : g_bad_main_min
        $error("MAIN_MIN must lie in [1, 2**CNT_W]");
    end
    if (SIDE_GREEN < 1 || SIDE_GREEN > MaxDur) begin : g_bad_side_green
        $error("SIDE_GREEN must lie in [1, 2**CNT_W]");
    end
    if (YELLOW < 1 || YELLOW > MaxDur) begin : g_bad_yellow
        $error("YELLOW must lie in [1, 2**CNT_W]");
    end
    if (ALLRED < 1 || ALLRED > MaxDur) begin : g_bad_allred
        $error("ALLRED must lie in [1, 2**CNT_W]");
    end
    if (WALK < 1 || WALK > MaxDur) begin : g_bad_walk
        $error("WALK must lie in [1, 2**CNT_W]");
    end
    if (FLASH_CYC < 1 || FLASH_CYC > MaxDur) begin : g_bad_flash_cyc
        $error("FLASH_CYC must lie in [1, 2**CNT_W]");
    end

    // Timers count down from DUR-1 so a phase lasts exactly DUR cycles.
    localparam logic [CNT_W-1:0] MainLd   = CNT_W'(MAIN_MIN - 1);
    localparam logic [CNT_W-1:0] SideLd   = CNT_W'(SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] YellowLd = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AllredLd = CNT_W'(ALLRED - 1);
    localparam logic [CNT_W-1:0] WalkLd   = CNT_W'(WALK - 1);
    localparam logic [CNT_W-1:0] FlashLd  = CNT_W'(FLASH_CYC - 1);

    localparam logic [1:0] LampRed    = 2'b00;
    localparam logic [1:0] LampYellow = 2'b01;
    localparam logic [1:0] LampGreen  = 2'b10;
    localparam logic [1:0] LampOff    = 2'b11;

    typedef enum logic [2:0] {
        StArm = 3'd0,
        StMg  = 3'd1,
        StMy  = 3'd2,
        StArs = 3'd3,
        StPw  = 3'd4,
        StSg  = 3'd5,
        StSy  = 3'd6,
        StFl  = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             side_pend_q, side_pend_d;
    logic             ped_pend_q, ped_pend_d;
    logic             blink_q, blink_d;
    logic             timer_zero;

    function automatic logic [CNT_W-1:0] load_val(input state_e s);
        logic [CNT_W-1:0] v;
        v = AllredLd;
        unique case (s)
            StArm, StArs: v = AllredLd;
            StMg:         v = MainLd;
            StMy, StSy:   v = YellowLd;
            StPw:         v = WalkLd;
            StSg:         v = SideLd;
            StFl:         v = FlashLd;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StArm;
            timer_q     <= AllredLd;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            blink_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            blink_q     <= blink_d;
        end
    end

    assign timer_zero = (timer_q == '0);

    // A request arriving during its own service phase is dropped; flash wipes all demand.
    always_comb begin
        side_pend_d = (side_pend_q | side_req) & (state_q != StSg) & ~flash;
        ped_pend_d  = (ped_pend_q | ped_req) & (state_q != StPw) & ~flash;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        blink_d = 1'b1;

        if (flash) begin
            if (state_q != StFl) begin
                state_d = StFl;
                timer_d = FlashLd;
            end else if (timer_zero) begin
                blink_d = ~blink_q;
                timer_d = FlashLd;
            end else begin
                blink_d = blink_q;
                timer_d = timer_q - 1'b1;
            end
        end else if (state_q == StFl) begin
            state_d = StArm;
            timer_d = AllredLd;
        end else begin
            if (timer_zero) begin
                unique case (state_q)
                    StArm: state_d = StMg;
                    StMg:  state_d = (side_pend_q | ped_pend_q) ? StMy : StMg;
                    StMy:  state_d = StArs;
                    StArs: state_d = ped_pend_q ? StPw : (side_pend_q ? StSg : StArm);
                    StPw:  state_d = side_pend_q ? StSg : StArm;
                    StSg:  state_d = StSy;
                    StSy:  state_d = StArm;
                    StFl:  state_d = StArm;
                endcase
            end
            // Timer saturates at zero so MG can wait for demand indefinitely.
            if (state_d != state_q) begin
                timer_d = load_val(state_d);
            end else if (!timer_zero) begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    always_comb begin
        main_light = LampRed;
        side_light = LampRed;
        walk       = 1'b0;
        phase      = state_q;
        unique case (state_q)
            StArm, StArs: ;
            StPw:  walk = 1'b1;
            StMg:  main_light = LampGreen;
            StMy:  main_light = LampYellow;
            StSg:  side_light = LampGreen;
            StSy:  side_light = LampYellow;
            StFl: begin
                main_light = blink_q ? LampYellow : LampOff;
                side_light = blink_q ? LampRed : LampOff;
            end
        endcase
    end

endmodule
